// File: rtl/axi_router_pkg.sv
// rtl/axi_router_pkg.sv - shared constants and types for the AXI3 master/slave router
package axi_router_pkg;

  localparam int ID_W_DEF   = 4;
  localparam int DATA_W_DEF = 32;

  localparam logic PORT_M1 = 1'b0;
  localparam logic PORT_M2 = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } r_state_e;

endpackage

// File: rtl/resp_slot.sv
// rtl/resp_slot.sv - one-entry registered valid/ready slot with generic payload
module resp_slot #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  input  logic         in_gate_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         full_o,
  input  logic         out_ready_i
);

  logic         full_q, full_d;
  logic [W-1:0] data_q, data_d;
  logic         pop;
  logic         accept;

  assign pop        = full_q & out_ready_i;
  assign in_ready_o = (!full_q | pop) & in_gate_i;
  assign accept     = in_valid_i & in_ready_o;
  assign out_data_o = data_q;
  assign full_o     = full_q;

  // A pop and an accept in the same cycle reload the slot and keep it full.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (accept) begin
      full_d = 1'b1;
      data_d = in_data_i;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/resp_rdata_demux_1to2.sv
// rtl/resp_rdata_demux_1to2.sv - routes B and R from one slave port back to two masters
module resp_rdata_demux_1to2
  import axi_router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ID_W   = ID_W_DEF
) (
  input  logic              aclk,
  input  logic              areset,
  input  logic [ID_W:0]     bid_s,
  input  logic [1:0]        bresp_s,
  input  logic              bvalid_s,
  output logic              bready_s,
  input  logic [ID_W:0]     rid_s,
  input  logic [DATA_W-1:0] rdata_s,
  input  logic [1:0]        rresp_s,
  input  logic              rlast_s,
  input  logic              rvalid_s,
  output logic              rready_s,
  output logic [ID_W-1:0]   bid_m1,
  output logic [ID_W-1:0]   bid_m2,
  output logic [1:0]        bresp_m1,
  output logic [1:0]        bresp_m2,
  output logic              bvalid_m1,
  output logic              bvalid_m2,
  input  logic              bready_m1,
  input  logic              bready_m2,
  output logic [ID_W-1:0]   rid_m1,
  output logic [ID_W-1:0]   rid_m2,
  output logic [DATA_W-1:0] rdata_m1,
  output logic [DATA_W-1:0] rdata_m2,
  output logic [1:0]        rresp_m1,
  output logic [1:0]        rresp_m2,
  output logic              rlast_m1,
  output logic              rlast_m2,
  output logic              rvalid_m1,
  output logic              rvalid_m2,
  input  logic              rready_m1,
  input  logic              rready_m2
);

  localparam int BW = ID_W + 3;
  localparam int RW = ID_W + DATA_W + 4;

  logic [BW-1:0] b_slot;
  logic          b_full;
  logic          b_port;
  logic          b_sel_ready;

  assign b_port      = b_slot[BW-1];
  assign b_sel_ready = (b_port == PORT_M2) ? bready_m2 : bready_m1;

  resp_slot #(.W(BW)) u_b_slot (
    .clk_i      (aclk),
    .rst_i      (areset),
    .in_data_i  ({bid_s, bresp_s}),
    .in_valid_i (bvalid_s),
    .in_gate_i  (1'b1),
    .in_ready_o (bready_s),
    .out_data_o (b_slot),
    .full_o     (b_full),
    .out_ready_i(b_sel_ready)
  );

  assign bvalid_m1 = b_full & (b_port == PORT_M1);
  assign bvalid_m2 = b_full & (b_port == PORT_M2);
  assign bid_m1    = b_slot[BW-2:2];
  assign bid_m2    = b_slot[BW-2:2];
  assign bresp_m1  = b_slot[1:0];
  assign bresp_m2  = b_slot[1:0];

  logic [RW-1:0] r_slot;
  logic          r_full;
  logic          r_port;
  logic          r_sel_ready;
  logic          lock_ok;
  logic          r_accept;
  r_state_e      r_state_q, r_state_d;
  logic          lock_port_q, lock_port_d;

  assign r_port      = r_slot[RW-1];
  assign r_sel_ready = (r_port == PORT_M2) ? rready_m2 : rready_m1;

  // Inside a burst only beats tagged for the locked master may enter the slot.
  assign lock_ok  = (r_state_q == R_IDLE) | (rid_s[ID_W] == lock_port_q);
  assign r_accept = rvalid_s & rready_s;

  resp_slot #(.W(RW)) u_r_slot (
    .clk_i      (aclk),
    .rst_i      (areset),
    .in_data_i  ({rid_s, rdata_s, rresp_s, rlast_s}),
    .in_valid_i (rvalid_s),
    .in_gate_i  (lock_ok),
    .in_ready_o (rready_s),
    .out_data_o (r_slot),
    .full_o     (r_full),
    .out_ready_i(r_sel_ready)
  );

  always_comb begin
    r_state_d   = r_state_q;
    lock_port_d = lock_port_q;
    case (r_state_q)
      R_IDLE: begin
        if (r_accept && !rlast_s) begin
          r_state_d   = R_BURST;
          lock_port_d = rid_s[ID_W];
        end
      end
      R_BURST: begin
        if (r_accept && rlast_s) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q   <= R_IDLE;
      lock_port_q <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      lock_port_q <= lock_port_d;
    end
  end

  assign rvalid_m1 = r_full & (r_port == PORT_M1);
  assign rvalid_m2 = r_full & (r_port == PORT_M2);
  assign rid_m1    = r_slot[RW-2:DATA_W+3];
  assign rid_m2    = r_slot[RW-2:DATA_W+3];
  assign rdata_m1  = r_slot[DATA_W+2:3];
  assign rdata_m2  = r_slot[DATA_W+2:3];
  assign rresp_m1  = r_slot[2:1];
  assign rresp_m2  = r_slot[2:1];
  assign rlast_m1  = r_slot[0];
  assign rlast_m2  = r_slot[0];

endmodule

// File: tb/tb_resp_rdata_demux_1to2.sv
// tb/tb_resp_rdata_demux_1to2.sv - scoreboard bench for the B/R return-path demux
module tb_resp_rdata_demux_1to2;

  logic        aclk = 1'b0;
  logic        areset;
  logic [4:0]  bid_s;
  logic [1:0]  bresp_s;
  logic        bvalid_s;
  logic        bready_s;
  logic [4:0]  rid_s;
  logic [31:0] rdata_s;
  logic [1:0]  rresp_s;
  logic        rlast_s;
  logic        rvalid_s;
  logic        rready_s;
  logic [3:0]  bid_m1, bid_m2;
  logic [1:0]  bresp_m1, bresp_m2;
  logic        bvalid_m1, bvalid_m2;
  logic        bready_m1, bready_m2;
  logic [3:0]  rid_m1, rid_m2;
  logic [31:0] rdata_m1, rdata_m2;
  logic [1:0]  rresp_m1, rresp_m2;
  logic        rlast_m1, rlast_m2;
  logic        rvalid_m1, rvalid_m2;
  logic        rready_m1, rready_m2;

  resp_rdata_demux_1to2 #(.DATA_W(32), .ID_W(4)) dut (
    .aclk(aclk), .areset(areset),
    .bid_s(bid_s), .bresp_s(bresp_s), .bvalid_s(bvalid_s), .bready_s(bready_s),
    .rid_s(rid_s), .rdata_s(rdata_s), .rresp_s(rresp_s), .rlast_s(rlast_s),
    .rvalid_s(rvalid_s), .rready_s(rready_s),
    .bid_m1(bid_m1), .bid_m2(bid_m2), .bresp_m1(bresp_m1), .bresp_m2(bresp_m2),
    .bvalid_m1(bvalid_m1), .bvalid_m2(bvalid_m2), .bready_m1(bready_m1), .bready_m2(bready_m2),
    .rid_m1(rid_m1), .rid_m2(rid_m2), .rdata_m1(rdata_m1), .rdata_m2(rdata_m2),
    .rresp_m1(rresp_m1), .rresp_m2(rresp_m2), .rlast_m1(rlast_m1), .rlast_m2(rlast_m2),
    .rvalid_m1(rvalid_m1), .rvalid_m2(rvalid_m2), .rready_m1(rready_m1), .rready_m2(rready_m2)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int hs_cyc;

  logic [5:0]  exp_b[2][$];
  logic [5:0]  got_b[2][$];
  logic [38:0] exp_r[2][$];
  logic [38:0] got_r[2][$];
  int          got_bcyc[$];
  int          got_rcyc[$];

  always @(posedge aclk) cyc <= cyc + 1;

  always @(negedge aclk) begin
    if (!areset) begin
      if (bvalid_m1 && bready_m1) begin got_b[0].push_back({bid_m1, bresp_m1}); got_bcyc.push_back(cyc); end
      if (bvalid_m2 && bready_m2) begin got_b[1].push_back({bid_m2, bresp_m2}); got_bcyc.push_back(cyc); end
      if (rvalid_m1 && rready_m1) begin got_r[0].push_back({rid_m1, rdata_m1, rresp_m1, rlast_m1}); got_rcyc.push_back(cyc); end
      if (rvalid_m2 && rready_m2) begin got_r[1].push_back({rid_m2, rdata_m2, rresp_m2, rlast_m2}); got_rcyc.push_back(cyc); end
    end
  end

  task automatic clear_sb();
    for (int m = 0; m < 2; m++) begin
      exp_b[m].delete(); got_b[m].delete(); exp_r[m].delete(); got_r[m].delete();
    end
    got_bcyc.delete(); got_rcyc.delete();
  endtask

  task automatic send_b(input logic [4:0] id, input logic [1:0] resp);
    int t;
    bid_s = id; bresp_s = resp; bvalid_s = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge aclk);
      if (bready_s) break;
      @(posedge aclk); #1;
    end
    n_vec++;
    if (t == 50) begin
      n_err++;
      $display("FAIL b_handshake: bready_s stayed %b, required 1 within 50 cycles", bready_s);
    end else begin
      exp_b[id[4]].push_back({id[3:0], resp});
      hs_cyc = cyc + 1;
      @(posedge aclk); #1;
    end
  endtask

  task automatic send_r(input logic [4:0] id, input logic [31:0] data,
                        input logic [1:0] resp, input logic last);
    int t;
    rid_s = id; rdata_s = data; rresp_s = resp; rlast_s = last; rvalid_s = 1'b1;
    for (t = 0; t < 50; t++) begin
      @(negedge aclk);
      if (rready_s) break;
      @(posedge aclk); #1;
    end
    n_vec++;
    if (t == 50) begin
      n_err++;
      $display("FAIL r_handshake: rready_s stayed %b, required 1 within 50 cycles", rready_s);
    end else begin
      exp_r[id[4]].push_back({id[3:0], data, resp, last});
      hs_cyc = cyc + 1;
      @(posedge aclk); #1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({bvalid_m1, bvalid_m2, rvalid_m1, rvalid_m2} !== 4'b0000 || {bready_s, rready_s} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_ctrl: valids=%b readies=%b, required 0000 and 11",
               {bvalid_m1, bvalid_m2, rvalid_m1, rvalid_m2}, {bready_s, rready_s});
    end
    n_vec++;
    if ({bid_m1, bid_m2, bresp_m1, bresp_m2, rid_m1, rid_m2, rdata_m1, rdata_m2,
         rresp_m1, rresp_m2, rlast_m1, rlast_m2} !== '0) begin
      n_err++;
      $display("FAIL reset_payload: rdata_m1=%h bid_m1=%h rid_m1=%h, required all zero",
               rdata_m1, bid_m1, rid_m1);
    end
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  task automatic test_b_routing();
    logic [5:0] e, g;
    clear_sb();
    bready_m1 = 1'b1; bready_m2 = 1'b1;
    send_b(5'h13, 2'b10);
    bvalid_s = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({bvalid_m2, bid_m2, bresp_m2, bvalid_m1} !== {1'b1, 4'h3, 2'b10, 1'b0}) begin
      n_err++;
      $display("FAIL b_route: v2=%b id2=%h resp2=%b v1=%b, required 1 3 10 0",
               bvalid_m2, bid_m2, bresp_m2, bvalid_m1);
    end
    repeat (3) @(posedge aclk);
    #1;
    for (int m = 0; m < 2; m++) begin
      while (exp_b[m].size() > 0) begin
        e = exp_b[m].pop_front(); n_vec++;
        if (got_b[m].size() == 0) begin n_err++; $display("FAIL b_route_deliver m%0d: got none, required %h", m + 1, e); end
        else begin g = got_b[m].pop_front(); if (g !== e) begin n_err++; $display("FAIL b_route_deliver m%0d: got %h, required %h", m + 1, g, e); end end
      end
      n_vec++;
      if (got_b[m].size() != 0) begin n_err++; $display("FAIL b_route_once m%0d: %0d extra, required 0", m + 1, got_b[m].size()); end
    end
  endtask

  task automatic test_b_throughput();
    logic [5:0] e, g;
    int first;
    clear_sb();
    for (int i = 0; i < 8; i++) begin
      send_b({i[0], i[3:0] ^ 4'h5}, i[1:0]);
      if (i == 0) first = hs_cyc;
    end
    bvalid_s = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_vec++;
    if (got_bcyc.size() != 8) begin
      n_err++; $display("FAIL b_tput_count: got %0d, required 8", got_bcyc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_vec++;
        if (got_bcyc[i] != first + i) begin
          n_err++; $display("FAIL b_tput_cycle[%0d]: got %0d, required %0d", i, got_bcyc[i], first + i);
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      while (exp_b[m].size() > 0) begin
        e = exp_b[m].pop_front(); n_vec++;
        if (got_b[m].size() == 0) begin n_err++; $display("FAIL b_tput_deliver m%0d: got none, required %h", m + 1, e); end
        else begin g = got_b[m].pop_front(); if (g !== e) begin n_err++; $display("FAIL b_tput_deliver m%0d: got %h, required %h", m + 1, g, e); end end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [38:0] e, g;
    logic [31:0] d[4];
    clear_sb();
    for (int i = 0; i < 4; i++) d[i] = $urandom;
    rready_m1 = 1'b0;
    send_r(5'h05, d[0], 2'b00, 1'b0);
    rid_s = 5'h05; rdata_s = d[1]; rlast_s = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge aclk);
      n_vec++;
      if ({rready_s, rvalid_m1, rdata_m1, rlast_m1} !== {1'b0, 1'b1, d[0], 1'b0}) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: rready_s=%b rvalid_m1=%b rdata_m1=%h, required 0 1 %h",
                 k, rready_s, rvalid_m1, rdata_m1, d[0]);
      end
      @(posedge aclk); #1;
    end
    rready_m1 = 1'b1;
    for (int i = 1; i < 4; i++) send_r(5'h05, d[i], 2'b01, (i == 3));
    rvalid_s = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    for (int m = 0; m < 2; m++) begin
      while (exp_r[m].size() > 0) begin
        e = exp_r[m].pop_front(); n_vec++;
        if (got_r[m].size() == 0) begin n_err++; $display("FAIL bp_deliver m%0d: got none, required %h", m + 1, e); end
        else begin g = got_r[m].pop_front(); if (g !== e) begin n_err++; $display("FAIL bp_deliver m%0d: got %h, required %h", m + 1, g, e); end end
      end
      n_vec++;
      if (got_r[m].size() != 0) begin n_err++; $display("FAIL bp_extra m%0d: %0d extra, required 0", m + 1, got_r[m].size()); end
    end
  endtask

  task automatic test_burst_lock();
    logic [38:0] e, g;
    clear_sb();
    rready_m1 = 1'b1; rready_m2 = 1'b1;
    send_r(5'h02, 32'hA000_0001, 2'b00, 1'b0);
    send_r(5'h02, 32'hA000_0002, 2'b00, 1'b0);
    rid_s = 5'h10; rdata_s = 32'hB000_0001; rlast_s = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      n_vec++;
      if (rready_s !== 1'b0 || (k > 0 && rvalid_m2 !== 1'b0)) begin
        n_err++;
        $display("FAIL lock_stall[%0d]: rready_s=%b rvalid_m2=%b, required 0 0", k, rready_s, rvalid_m2);
      end
      @(posedge aclk); #1;
    end
    send_r(5'h02, 32'hA000_0003, 2'b00, 1'b0);
    send_r(5'h02, 32'hA000_0004, 2'b00, 1'b1);
    send_r(5'h10, 32'hB000_0001, 2'b11, 1'b1);
    rvalid_s = 1'b0;
    @(negedge aclk);
    n_vec++;
    if ({rvalid_m2, rid_m2, rdata_m2, rresp_m2, rvalid_m1} !== {1'b1, 4'h0, 32'hB000_0001, 2'b11, 1'b0}) begin
      n_err++;
      $display("FAIL lock_release: rvalid_m2=%b rid_m2=%h rdata_m2=%h rvalid_m1=%b, required 1 0 b0000001 0",
               rvalid_m2, rid_m2, rdata_m2, rvalid_m1);
    end
    repeat (3) @(posedge aclk);
    #1;
    for (int m = 0; m < 2; m++) begin
      while (exp_r[m].size() > 0) begin
        e = exp_r[m].pop_front(); n_vec++;
        if (got_r[m].size() == 0) begin n_err++; $display("FAIL lock_deliver m%0d: got none, required %h", m + 1, e); end
        else begin g = got_r[m].pop_front(); if (g !== e) begin n_err++; $display("FAIL lock_deliver m%0d: got %h, required %h", m + 1, g, e); end end
      end
      n_vec++;
      if (got_r[m].size() != 0) begin n_err++; $display("FAIL lock_extra m%0d: %0d extra, required 0", m + 1, got_r[m].size()); end
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [38:0] e, g;
    clear_sb();
    send_r(5'h07, 32'hC000_0001, 2'b00, 1'b0);
    send_r(5'h07, 32'hC000_0002, 2'b00, 1'b0);
    rid_s = 5'h07; rdata_s = 32'hC000_0003; rlast_s = 1'b0;
    areset = 1'b1;
    #1;
    n_vec++;
    if ({bvalid_m1, bvalid_m2, rvalid_m1, rvalid_m2, bready_s, rready_s, rdata_m1} !== {6'b000011, 32'h0}) begin
      n_err++;
      $display("FAIL mid_reset: valids=%b bready_s=%b rready_s=%b rdata_m1=%h, required 0000 1 1 0",
               {bvalid_m1, bvalid_m2, rvalid_m1, rvalid_m2}, bready_s, rready_s, rdata_m1);
    end
    rvalid_s = 1'b0;
    @(posedge aclk); @(posedge aclk); #1;
    areset = 1'b0;
    clear_sb();
    send_r(5'h1A, 32'hD00D_F00D, 2'b10, 1'b1);
    rvalid_s = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    for (int m = 0; m < 2; m++) begin
      while (exp_r[m].size() > 0) begin
        e = exp_r[m].pop_front(); n_vec++;
        if (got_r[m].size() == 0) begin n_err++; $display("FAIL post_reset m%0d: got none, required %h", m + 1, e); end
        else begin g = got_r[m].pop_front(); if (g !== e) begin n_err++; $display("FAIL post_reset m%0d: got %h, required %h", m + 1, g, e); end end
      end
      n_vec++;
      if (got_r[m].size() != 0) begin n_err++; $display("FAIL post_reset_extra m%0d: %0d extra, required 0", m + 1, got_r[m].size()); end
    end
  endtask

  task automatic test_single_beats();
    logic [38:0] e, g;
    int first;
    clear_sb();
    for (int i = 0; i < 6; i++) begin
      send_r({i[0], i[3:0]}, $urandom, i[1:0], 1'b1);
      if (i == 0) first = hs_cyc;
    end
    rvalid_s = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    n_vec++;
    if (got_rcyc.size() != 6) begin
      n_err++; $display("FAIL single_count: got %0d, required 6", got_rcyc.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_vec++;
        if (got_rcyc[i] != first + i) begin
          n_err++; $display("FAIL single_cycle[%0d]: got %0d, required %0d", i, got_rcyc[i], first + i);
        end
      end
    end
    for (int m = 0; m < 2; m++) begin
      while (exp_r[m].size() > 0) begin
        e = exp_r[m].pop_front(); n_vec++;
        if (got_r[m].size() == 0) begin n_err++; $display("FAIL single_deliver m%0d: got none, required %h", m + 1, e); end
        else begin g = got_r[m].pop_front(); if (g !== e) begin n_err++; $display("FAIL single_deliver m%0d: got %h, required %h", m + 1, g, e); end end
      end
    end
  endtask

  initial begin
    areset = 1'b1;
    bid_s = '0; bresp_s = '0; bvalid_s = 1'b0;
    rid_s = '0; rdata_s = '0; rresp_s = '0; rlast_s = 1'b0; rvalid_s = 1'b0;
    bready_m1 = 1'b1; bready_m2 = 1'b1; rready_m1 = 1'b1; rready_m2 = 1'b1;
    repeat (2) @(posedge aclk);
    test_reset();
    test_b_routing();
    test_b_throughput();
    test_backpressure();
    test_burst_lock();
    test_reset_mid_burst();
    test_single_beats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/resp_rdata_demux_1to2.md
# resp_rdata_demux_1to2

Return-path router between one AXI3 slave port and two master ports: steers write responses (B) and read data (R) from the slave back to master 1 or master 2. It is the return half of the 2-to-1 master-side router. The slave-side ID carries a port tag in its MSB (0 = m1, 1 = m2), which this block strips. Each channel has a one-entry registered output slot, and the R channel holds a burst lock so beats of one burst are never split across masters.

## Interface
Parameters:
- DATA_W, 32, read data width
- ID_W, 4, master-side ID width; slave-side ID is ID_W+1 bits

Ports:
- aclk  in  1  clock, all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- bid_s  in  ID_W+1  slave write-response ID, MSB = port tag
- bresp_s  in  2  slave write response
- bvalid_s  in  1  slave B valid
- bready_s  out  1  B ready to slave
- rid_s  in  ID_W+1  slave read ID, MSB = port tag
- rdata_s  in  DATA_W  slave read data
- rresp_s  in  2  slave read response
- rlast_s  in  1  last beat of read burst
- rvalid_s  in  1  slave R valid
- rready_s  out  1  R ready to slave
- bid_m1/bid_m2  out  ID_W  tag-stripped ID to each master
- bresp_m1/bresp_m2  out  2  write response
- bvalid_m1/bvalid_m2  out  1  B valid
- bready_m1/bready_m2  in  1  B ready
- rid_m1/rid_m2  out  ID_W  tag-stripped read ID
- rdata_m1/rdata_m2  out  DATA_W  read data
- rresp_m1/rresp_m2  out  2  read response
- rlast_m1/rlast_m2  out  1  last beat
- rvalid_m1/rvalid_m2  out  1  R valid
- rready_m1/rready_m2  in  1  R ready

## Operation
- B slot: holds {port, id[ID_W-1:0], resp} plus a full flag.
  - Accept when bvalid_s & bready_s. Capture port = bid_s[ID_W].
  - bvalid_mX = full & (port == X). The non-selected master always sees bvalid 0.
  - pop = full & bready of the selected master. bready_s = !full | pop, which gives pass-through at one beat per cycle.
  - Simultaneous pop and accept: the slot reloads and stays full.
- R slot: same structure with {port, id, data, resp, last}. rready_s = (!full | pop) & lock_ok.
- R burst FSM, states R_IDLE and R_BURST(lock_port):
  - R_IDLE: lock_ok = 1. An accepted beat with rlast_s = 0 moves to R_BURST and sets lock_port = rid_s[ID_W]. A beat with rlast_s = 1 stays in R_IDLE.
  - R_BURST: lock_ok = (rid_s[ID_W] == lock_port). A beat for the other port is stalled, with rready_s low, until the locked burst ends. An accepted beat with rlast_s = 1 returns to R_IDLE.
- Master-side payload outputs are driven from the slot registers to both masters; only valid is qualified.
- Response codes pass through unmodified. No counting or checking of burst length.

## Timing
- Latency: slave handshake in cycle N makes the master valid visible in cycle N+1. Sustained throughput is 1 beat/cycle per channel.
- Combinational paths: bready_mX -> bready_s and rready_mX/rid_s -> rready_s. No path from slave valid to master valid.
- Once asserted, a master valid stays high with stable payload until its ready. The slot never changes while full and not popping.
- Reset (async assert, sync release):
  - All valids 0, bready_s = 1, rready_s = 1, slots empty, FSM R_IDLE.
  - All payload registers 0, so every master-side ID, data, resp and last output reads 0.
  - Reset mid-burst drops the held beat and the lock.
- B and R channels are fully independent. Back-to-back B responses to alternating masters incur no bubble.

## Structure
- Package axi_router_pkg: ID_W, DATA_W defaults, port tag constants PORT_M1 = 0 and PORT_M2 = 1, AXI response codes (OKAY, EXOKAY, SLVERR, DECERR), R FSM state encoding.
- Sub-module resp_slot: generic one-entry valid/ready register with a payload width parameter. Instantiated once for B and once for R. Routing and lock logic live in the top.

## Test plan
- B routing: bid_s = 5'h13, bresp = 2'b10 -> next cycle bvalid_m2 = 1, bid_m2 = 4'h3, bresp_m2 = 2'b10, bvalid_m1 = 0. With bready_m2 held 1 for 3 cycles, one response is delivered exactly once.
- Backpressure: rready_m1 = 0 for 5 cycles during a 4-beat m1 burst -> rready_s low after the first beat, rdata_m1 stable, all 4 beats delivered in order with rlast on beat 4 only.
- Burst lock: m1 burst of 4 beats, and after beat 2 the slave presents rid_s = 5'h10 -> rready_s = 0 while rid_s = 5'h10 is presented. m2 receives nothing until the m1 rlast beat is accepted; then the m2 beat is accepted and delivered next cycle.
- Throughput: 8 back-to-back B responses alternating tags with both masters ready -> 8 responses in 8 consecutive cycles, first one cycle after the first handshake.
- Reset mid-burst: assert areset during beat 2 of 4 -> all valids 0 immediately, bready_s = rready_s = 1. After release, a new m2 single-beat read (rlast_s = 1) is routed correctly.
- Single-beat reads to alternating masters -> FSM stays in R_IDLE and delivers 1 beat/cycle.
